// File: rtl/life_pkg.sv
// Shared types and helpers for the 8x8 Game of Life sequencer.
// Cells outside the 8x8 board are treated as permanently dead.
package life_pkg;

    localparam int GRID_W = 64;
    localparam int ROW_W  = 8;

    typedef logic [GRID_W-1:0] grid_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    function automatic logic cell_at(grid_t g, int r, int c);
        logic [5:0] idx;
        logic       v;
        idx = 6'(r * ROW_W + c);
        if ((r < 0) || (r >= ROW_W) || (c < 0) || (c >= ROW_W)) begin
            v = 1'b0;
        end else begin
            v = g[idx];
        end
        return v;
    endfunction

    function automatic logic [3:0] neighbour_count(grid_t g, int r, int c);
        logic [3:0] n;
        n = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!((dr == 0) && (dc == 0))) begin
                    n = n + {3'b000, cell_at(g, r + dr, c + dc)};
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/life_sequencer_datapath.sv
// Combinational next-generation logic: birth on 3 neighbours, survival on 2 or 3.
module life_sequencer_datapath
    import life_pkg::*;
(
    input  logic [63:0] grid,
    output logic [63:0] grid_evolve
);

    // Apply the life rule to every cell of the current grid.
    always_comb begin
        grid_evolve = 64'h0;
        for (int r = 0; r < ROW_W; r++) begin
            for (int c = 0; c < ROW_W; c++) begin
                grid_evolve[6'(r * ROW_W + c)] =
                    (neighbour_count(grid, r, c) == 4'd3) ||
                    (grid[6'(r * ROW_W + c)] && (neighbour_count(grid, r, c) == 4'd2));
            end
        end
    end

endmodule

// File: rtl/life_sequencer.sv
// Game of Life sequencer: load, single-step and divided free-run of an 8x8 grid.
// Optional auto-halt on stable/extinct grids is enabled by defining LIFE_AUTO_HALT_EN.
module life_sequencer
    import life_pkg::*;
#(
    parameter int STEP_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [63:0] init_state,
    input  logic        run,
    input  logic        step,
    output logic [63:0] grid,
    output logic [15:0] gen_count,
    output logic        gen_valid,
    output logic        busy,
    output logic        stable,
    output logic        extinct
);

    localparam logic [15:0] DIV_RELOAD = 16'(STEP_DIV - 1);

    state_t      state_r, state_nxt_s;
    grid_t       grid_r, grid_nxt_s, next_gen_s;
    logic [15:0] gen_count_r, gen_count_nxt_s;
    logic [15:0] div_r, div_nxt_s;
    logic        gen_valid_r, gen_valid_nxt_s;
    logic        commit_s;

    life_sequencer_datapath u_datapath (
        .grid        (grid_r),
        .grid_evolve (next_gen_s)
    );

`ifdef LIFE_AUTO_HALT_EN
    // Look one generation past the commit to decide whether the result has settled.
    grid_t after_commit_s;

    life_sequencer_datapath u_halt_probe (
        .grid        (next_gen_s),
        .grid_evolve (after_commit_s)
    );
`endif

    // Next-state, divider and commit decision; load outranks step/run.
    always_comb begin
        state_nxt_s = state_r;
        div_nxt_s   = div_r;
        commit_s    = 1'b0;
        if (load) begin
            state_nxt_s = IDLE;
            div_nxt_s   = 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    commit_s = step;
                    if (run) begin
                        state_nxt_s = RUN;
                        div_nxt_s   = DIV_RELOAD;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state_nxt_s = IDLE;
                        div_nxt_s   = 16'd0;
                    end else if (div_r == 16'd0) begin
                        commit_s  = 1'b1;
                        div_nxt_s = DIV_RELOAD;
`ifdef LIFE_AUTO_HALT_EN
                        if ((after_commit_s == next_gen_s) || (next_gen_s == 64'h0)) begin
                            state_nxt_s = HALT;
                        end else begin
                            state_nxt_s = RUN;
                        end
`else
                        state_nxt_s = RUN;
`endif
                    end else begin
                        div_nxt_s = div_r - 16'd1;
                    end
                end
                HALT: begin
                    state_nxt_s = HALT;
                end
                default: begin
                    state_nxt_s = IDLE;
                    div_nxt_s   = 16'd0;
                end
            endcase
        end
    end

    // Data updates derived from the control decision.
    always_comb begin
        grid_nxt_s      = grid_r;
        gen_count_nxt_s = gen_count_r;
        gen_valid_nxt_s = 1'b0;
        if (load) begin
            grid_nxt_s      = init_state;
            gen_count_nxt_s = 16'd0;
        end else if (commit_s) begin
            grid_nxt_s      = next_gen_s;
            gen_count_nxt_s = gen_count_r + 16'd1;
            gen_valid_nxt_s = 1'b1;
        end else begin
            grid_nxt_s = grid_r;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            grid_r      <= 64'h0;
            gen_count_r <= 16'd0;
            div_r       <= 16'd0;
            gen_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            grid_r      <= grid_nxt_s;
            gen_count_r <= gen_count_nxt_s;
            div_r       <= div_nxt_s;
            gen_valid_r <= gen_valid_nxt_s;
        end
    end

    assign grid      = grid_r;
    assign gen_count = gen_count_r;
    assign gen_valid = gen_valid_r;
    assign busy      = (state_r == RUN);
    assign stable    = (next_gen_s == grid_r);
    assign extinct   = (grid_r == 64'h0);

endmodule

// File: tb/tb_life_sequencer.sv
// Self-checking bench for life_sequencer: directed scenarios plus random traffic
// against a board-level reference model.
module tb_life_sequencer;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset, load, run, step;
    logic [63:0] init_state;
    logic [63:0] grid;
    logic [15:0] gen_count;
    logic        gen_valid, busy, stable, extinct;

    int n_checks = 0;
    int n_fail   = 0;
    int gv_seen  = 0;
    bit chk_en   = 1'b1;

    // Reference model state
    logic [63:0] m_grid;
    logic [15:0] m_cnt;
    int          m_mode;   // 0 idle, 1 run, 2 halt
    int          m_phase;
    logic        m_gv;

    life_sequencer #(.STEP_DIV(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .init_state (init_state),
        .run        (run),
        .step       (step),
        .grid       (grid),
        .gen_count  (gen_count),
        .gen_valid  (gen_valid),
        .busy       (busy),
        .stable     (stable),
        .extinct    (extinct)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Life rule on a zero-padded 10x10 board.
    function automatic logic [63:0] life_next(input logic [63:0] g);
        bit          board [0:9][0:9];
        logic [63:0] res;
        int          cnt;
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 10; x++)
                board[y][x] = 1'b0;
        for (int k = 0; k < 64; k++)
            board[k / 8 + 1][k % 8 + 1] = g[k];
        res = 64'h0;
        for (int y = 1; y <= 8; y++) begin
            for (int x = 1; x <= 8; x++) begin
                cnt = 0;
                for (int yy = y - 1; yy <= y + 1; yy++)
                    for (int xx = x - 1; xx <= x + 1; xx++)
                        cnt += int'(board[yy][xx]);
                cnt -= int'(board[y][x]);
                res[(y - 1) * 8 + (x - 1)] = (cnt == 3) || (board[y][x] && cnt == 2);
            end
        end
        return res;
    endfunction

    task automatic model_edge();
        bit commit, was_run;
        commit  = 1'b0;
        was_run = 1'b0;
        if (reset) begin
            m_grid = 64'h0; m_cnt = 16'd0; m_mode = 0; m_phase = 0;
        end else if (load) begin
            m_grid = init_state; m_cnt = 16'd0; m_mode = 0; m_phase = 0;
        end else begin
            case (m_mode)
                0: begin
                    commit = step;
                    if (run) begin m_mode = 1; m_phase = 0; end
                end
                1: begin
                    if (!run) m_mode = 0;
                    else begin
                        m_phase++;
                        if (m_phase % DIV == 0) begin commit = 1'b1; was_run = 1'b1; end
                    end
                end
                default: ;
            endcase
        end
        if (commit) begin
            m_grid = life_next(m_grid);
            m_cnt  = m_cnt + 16'd1;
`ifdef LIFE_AUTO_HALT_EN
            if (was_run && ((life_next(m_grid) == m_grid) || (m_grid == 64'h0))) m_mode = 2;
`endif
        end
        m_gv = commit;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        if (gen_valid) gv_seen++;
        if (chk_en) begin
            check("grid", grid, m_grid);
            check("gen_count", 64'(gen_count), 64'(m_cnt));
            check("gen_valid", 64'(gen_valid), 64'(m_gv));
            check("busy", 64'(busy), 64'(m_mode == 1));
            check("stable", 64'(stable), 64'(life_next(m_grid) == m_grid));
            check("extinct", 64'(extinct), 64'(m_grid == 64'h0));
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; load = 1'b0; run = 1'b0; step = 1'b0;
    endtask

    task automatic do_load(input logic [63:0] v);
        idle_inputs(); load = 1'b1; init_state = v; tick(); load = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1; tick(); step = 1'b0;
    endtask

    initial begin
        int gv0;
        logic [16:0] commit_mask;

        idle_inputs();
        init_state = 64'h0;
        m_grid = 64'h0; m_cnt = 16'd0; m_mode = 0; m_phase = 0; m_gv = 1'b0;

        // Reset state
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        check("rst_grid", grid, 64'h0);
        check("rst_cnt", 64'(gen_count), 64'h0);
        check("rst_flags", {60'h0, gen_valid, busy, stable, extinct}, 64'h3);

        // Blinker single steps
        do_load(64'h0000_0000_0070_0000);
        gv0 = gv_seen;
        do_step(); check("blink1", grid, 64'h0000_0000_2020_2000);
        do_step(); check("blink2", grid, 64'h0000_0000_0070_0000);
        do_step(); check("blink3", grid, 64'h0000_0000_2020_2000);
        check("blink_cnt", 64'(gen_count), 64'd3);
        check("blink_gv", 64'(gv_seen - gv0), 64'd3);

        // Divided run timing
        do_load(64'h0000_0000_0070_0000);
        run = 1'b1;
        commit_mask = 17'h0;
        for (int i = 0; i <= 16; i++) begin
            tick();
            commit_mask[i] = gen_valid;
            check("run_busy", 64'(busy), 64'd1);
        end
        check("run_commits", 64'(commit_mask), 64'h1_1110);
        check("run_cnt", 64'(gen_count), 64'd4);
        run = 1'b0; tick();

        // Still life block
        do_load(64'h0000_0000_1818_0000);
        check("block_stable", 64'(stable), 64'd1);
        run = 1'b1;
        for (int i = 0; i < 12; i++) tick();
`ifdef LIFE_AUTO_HALT_EN
        check("block_halt_cnt", 64'(gen_count), 64'd1);
        check("block_halt_busy", 64'(busy), 64'd0);
`else
        check("block_run_cnt", 64'(gen_count), 64'd2);
`endif
        run = 1'b0; tick();

        // Extinction
        do_load(64'h0000_0000_0000_0001);
        do_step();
        check("ext_grid", grid, 64'h0);
        check("ext_flag", 64'(extinct), 64'd1);
        tick();
        do_step();
        check("ext_grid2", grid, 64'h0);
        check("ext_cnt", 64'(gen_count), 64'd2);

        // Priority
        do_load(64'h0000_0000_0070_0000);
        reset = 1'b1; load = 1'b1; step = 1'b1; init_state = 64'hFFFF_0000_FFFF_0000;
        tick(); idle_inputs();
        check("prio_rst_grid", grid, 64'h0);
        check("prio_rst_cnt", 64'(gen_count), 64'h0);
        do_load(64'h0000_0000_0070_0000);
        run = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        load = 1'b1; init_state = 64'h0000_3C00_0000_0042;
        tick(); load = 1'b0;
        check("prio_load_grid", grid, 64'h0000_3C00_0000_0042);
        check("prio_load_busy", 64'(busy), 64'd0);
        check("prio_load_gv", 64'(gen_valid), 64'd0);
        run = 1'b0; tick();

        // Counter wrap via continuous steps on an empty grid
        do_load(64'h0);
        chk_en = 1'b0;
        step = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        chk_en = 1'b1;
        check("wrap_pre", 64'(gen_count), 64'hFFFF);
        tick(); step = 1'b0;
        check("wrap_cnt", 64'(gen_count), 64'h0);
        check("wrap_gv", 64'(gen_valid), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            load  = ($urandom_range(0, 15) == 0);
            step  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) run = ~run;
            init_state = {$urandom, $urandom} & {$urandom, $urandom};
            tick();
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
